// File: rtl/chunk_to_fragment_if.sv
// chunk_to_fragment_if: bundles the chunk-in and fragment-out handshakes.
// master is the unpacker's view, slave is the view of the surrounding logic.
interface chunk_to_fragment_if #(
    parameter int S_IN      = 8,
    parameter int S_MAX_OUT = 4,
    parameter int W         = 8
);
    localparam int SW = $clog2(S_MAX_OUT + 1);
    localparam int CW = $clog2(2 * S_IN + 1);

    logic                        i_chunk_valid;
    logic [S_IN-1:0][W-1:0]      i_chunk;
    logic                        o_us_ready;
    logic                        i_ds_ready;
    logic [SW-1:0]               i_req_size;
    logic                        o_frag_valid;
    logic [SW-1:0]               o_frag_size;
    logic [S_MAX_OUT-1:0][W-1:0] o_frag;
    logic [CW-1:0]               o_buf_cnt;

    modport master (
        input  i_chunk_valid, i_chunk, i_ds_ready, i_req_size,
        output o_us_ready, o_frag_valid, o_frag_size, o_frag, o_buf_cnt
    );

    modport slave (
        output i_chunk_valid, i_chunk, i_ds_ready, i_req_size,
        input  o_us_ready, o_frag_valid, o_frag_size, o_frag, o_buf_cnt
    );
endinterface

// File: rtl/chunk_to_fragment.sv
// chunk_to_fragment: unpacks S_IN-element chunks into downstream-sized fragments
// through a two-page ring buffer, so one chunk can land while the previous drains.
module chunk_to_fragment #(
    parameter int S_IN      = 8,
    parameter int S_MAX_OUT = 4,
    parameter int W         = 8
) (
    input logic                 i_clk,
    input logic                 i_async_rst_n,
    chunk_to_fragment_if.master bus
);
    localparam int N  = 2 * S_IN;
    localparam int PW = $clog2(N);
    localparam int AW = PW + 1;
    localparam int SW = $clog2(S_MAX_OUT + 1);
    localparam int CW = $clog2(N + 1);

    if (S_IN < 1 || S_MAX_OUT < 1 || S_MAX_OUT > S_IN) begin : g_param_check
        $error("chunk_to_fragment: requires 1 <= S_MAX_OUT <= S_IN");
    end

    logic [N-1:0][W-1:0] buf_q;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                wr_page_q, wr_page_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       clip, eff;
    logic [AW-1:0]       adv, idx;
    logic                push, pop;

    // Ready looks only at registered state, never at the downstream handshake.
    assign bus.o_us_ready   = i_async_rst_n && (cnt_q <= CW'(S_IN));
    assign push             = bus.i_chunk_valid && bus.o_us_ready;
    assign clip             = (bus.i_req_size > SW'(S_MAX_OUT)) ? SW'(S_MAX_OUT) : bus.i_req_size;
    assign eff              = (CW'(clip) > cnt_q) ? SW'(cnt_q) : clip;
    assign bus.o_frag_valid = eff != '0;
    assign bus.o_frag_size  = eff;
    assign bus.o_buf_cnt    = cnt_q;
    assign pop              = bus.o_frag_valid && bus.i_ds_ready;

    always_comb begin
        bus.o_frag = '0;
        idx = '0;
        for (int i = 0; i < S_MAX_OUT; i++) begin
            idx = {1'b0, rd_ptr_q} + AW'(i);
            if (SW'(i) < eff) bus.o_frag[i] = buf_q[PW'((idx >= AW'(N)) ? idx - AW'(N) : idx)];
        end
    end

    assign adv       = {1'b0, rd_ptr_q} + (pop ? AW'(eff) : AW'(0));
    assign rd_ptr_d  = PW'((adv >= AW'(N)) ? adv - AW'(N) : adv);
    assign wr_page_d = push ? ~wr_page_q : wr_page_q;
    assign cnt_d     = cnt_q + (push ? CW'(S_IN) : CW'(0)) - (pop ? CW'(eff) : CW'(0));

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            rd_ptr_q  <= '0;
            wr_page_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_page_q <= wr_page_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage needs no reset: reads are masked by eff, which is 0 while empty.
    always_ff @(posedge i_clk) begin
        if (push && wr_page_q) buf_q[N-1:S_IN] <= bus.i_chunk;
        if (push && !wr_page_q) buf_q[S_IN-1:0] <= bus.i_chunk;
    end
endmodule

// File: tb/tb_chunk_to_fragment.sv
// tb_chunk_to_fragment: scoreboard bench; accepted chunk elements queue up and
// every presented fragment, size, count and ready is compared against that queue.
module tb_chunk_to_fragment;
    localparam int S_IN = 8, S_MAX_OUT = 4, W = 8;
    localparam int SW = $clog2(S_MAX_OUT + 1);
    localparam int CW = $clog2(2 * S_IN + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0, errors = 0;
    int next_val = 0, left = 0;
    logic [W-1:0] q[$];

    chunk_to_fragment_if #(.S_IN(S_IN), .S_MAX_OUT(S_MAX_OUT), .W(W)) bus ();
    chunk_to_fragment #(.S_IN(S_IN), .S_MAX_OUT(S_MAX_OUT), .W(W)) dut (
        .i_clk(clk), .i_async_rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive_chunk();
        bus.i_chunk_valid = left > 0;
        for (int j = 0; j < S_IN; j++) bus.i_chunk[j] = W'(next_val + j);
    endtask

    function automatic int exp_size();
        int r = int'(bus.i_req_size);
        if (r > S_MAX_OUT) r = S_MAX_OUT;
        return (r < q.size()) ? r : q.size();
    endfunction

    function automatic logic [9:0] exp_status();
        int es = exp_size();
        return {es != 0, SW'(es), q.size() <= S_IN, CW'(q.size())};
    endfunction

    function automatic logic [S_MAX_OUT-1:0][W-1:0] exp_frag();
        logic [S_MAX_OUT-1:0][W-1:0] f = '0;
        for (int i = 0; i < exp_size(); i++) f[i] = q[i];
        return f;
    endfunction

    function automatic logic [9:0] st();
        return {bus.o_frag_valid, bus.o_frag_size, bus.o_us_ready, bus.o_buf_cnt};
    endfunction

    // Applies this cycle's pop and push to the model, then moves to the next negedge.
    task automatic advance();
        if (bus.i_ds_ready) for (int n = exp_size(); n > 0; n--) void'(q.pop_front());
        if (bus.i_chunk_valid && bus.o_us_ready) begin
            for (int j = 0; j < S_IN; j++) q.push_back(W'(next_val + j));
            next_val += S_IN;
            left--;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        bus.i_chunk_valid = 1'b1;
        bus.i_chunk = '0;
        bus.i_req_size = 3'd4;
        bus.i_ds_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (st() !== 10'b0) begin errors++; $display("FAIL reset_status: got %h want 000", st()); end
        checks++;
        if (bus.o_frag !== '0) begin errors++; $display("FAIL reset_frag: got %h want 0", bus.o_frag); end
        bus.i_chunk_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (st() !== 10'b0000100000) begin errors++; $display("FAIL reset_release: got %h want 020", st()); end
        @(negedge clk);
    endtask

    task automatic test_single();
        next_val = 0; left = 1; bus.i_req_size = 3'd4; bus.i_ds_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_chunk(); #1;
            checks++;
            if (st() !== exp_status()) begin errors++; $display("FAIL single_status c%0d: got %h want %h", c, st(), exp_status()); end
            checks++;
            if (bus.o_frag !== exp_frag()) begin errors++; $display("FAIL single_frag c%0d: got %h want %h", c, bus.o_frag, exp_frag()); end
            advance();
        end
    endtask

    task automatic test_tail();
        next_val = 0; left = 1; bus.i_req_size = 3'd3; bus.i_ds_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive_chunk(); #1;
            checks++;
            if (st() !== exp_status()) begin errors++; $display("FAIL tail_status c%0d: got %h want %h", c, st(), exp_status()); end
            checks++;
            if (bus.o_frag !== exp_frag()) begin errors++; $display("FAIL tail_frag c%0d: got %h want %h", c, bus.o_frag, exp_frag()); end
            advance();
        end
    endtask

    task automatic test_backpressure();
        next_val = 100; left = 3; bus.i_req_size = 3'd4;
        for (int c = 0; c < 12; c++) begin
            bus.i_ds_ready = c >= 4;
            drive_chunk(); #1;
            checks++;
            if (st() !== exp_status()) begin errors++; $display("FAIL bp_status c%0d: got %h want %h", c, st(), exp_status()); end
            checks++;
            if (bus.o_frag !== exp_frag()) begin errors++; $display("FAIL bp_frag c%0d: got %h want %h", c, bus.o_frag, exp_frag()); end
            if (c == 3) begin
                checks++;
                if (bus.o_buf_cnt !== CW'(16) || bus.o_us_ready !== 1'b0)
                    begin errors++; $display("FAIL bp_full: got cnt %0d ready %b want 16/0", bus.o_buf_cnt, bus.o_us_ready); end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        int c = 0;
        int maxc = 0;
        next_val = 0; left = 6; bus.i_req_size = 3'd3; bus.i_ds_ready = 1'b1;
        while ((left > 0 || q.size() > 0) && c < 100) begin
            drive_chunk(); #1;
            checks++;
            if (st() !== exp_status()) begin errors++; $display("FAIL wrap_status c%0d: got %h want %h", c, st(), exp_status()); end
            checks++;
            if (bus.o_frag !== exp_frag()) begin errors++; $display("FAIL wrap_frag c%0d: got %h want %h", c, bus.o_frag, exp_frag()); end
            if (int'(bus.o_buf_cnt) > maxc) maxc = int'(bus.o_buf_cnt);
            advance();
            c++;
        end
        checks++;
        if (c >= 100) begin errors++; $display("FAIL wrap_timeout: got %0d cycles want < 100", c); end
        checks++;
        if (maxc > 16 || maxc < 8) begin errors++; $display("FAIL wrap_max_cnt: got %0d want 8..16", maxc); end
        #1;
        checks++;
        if (st() !== exp_status()) begin errors++; $display("FAIL wrap_drained: got %h want %h", st(), exp_status()); end
    endtask

    task automatic test_clip_reset();
        int req_tab[5] = '{0, 0, 7, 2, 0};
        next_val = 200; left = 2; bus.i_ds_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.i_req_size = SW'(req_tab[c]);
            drive_chunk(); #1;
            checks++;
            if (st() !== exp_status()) begin errors++; $display("FAIL clip_status c%0d: got %h want %h", c, st(), exp_status()); end
            checks++;
            if (bus.o_frag !== exp_frag()) begin errors++; $display("FAIL clip_frag c%0d: got %h want %h", c, bus.o_frag, exp_frag()); end
            advance();
        end
        bus.i_req_size = 3'd4;
        #1;
        checks++;
        if (bus.o_buf_cnt !== CW'(10)) begin errors++; $display("FAIL clip_pre_reset_cnt: got %0d want 10", bus.o_buf_cnt); end
        next_val = 50; left = 1;
        drive_chunk();
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (st() !== 10'b0 || bus.o_frag !== '0) begin errors++; $display("FAIL midreset_outputs: got %h/%h want 000/0", st(), bus.o_frag); end
        @(posedge clk);
        #1;
        checks++;
        if (st() !== 10'b0) begin errors++; $display("FAIL midreset_inflight: got %h want 000", st()); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_chunk(); #1;
            checks++;
            if (st() !== exp_status()) begin errors++; $display("FAIL post_reset_status c%0d: got %h want %h", c, st(), exp_status()); end
            checks++;
            if (bus.o_frag !== exp_frag()) begin errors++; $display("FAIL post_reset_frag c%0d: got %h want %h", c, bus.o_frag, exp_frag()); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tail();
        test_backpressure();
        test_wrap();
        test_clip_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
